wide_unpack_fifo: RTL and testbench

- Storage and width-conversion stage between the wide (256-bit) memory-B read return and the 16-bit AXI-Stream style output of the credit-return path.
- Accepts one 256-bit line per write, tagged with the number of valid 16-bit words, and emits those words one at a time, lowest word first, in show-ahead (first-word-fall-through) form.
- The upstream credit counter guarantees it never writes into a full buffer; overflow is still detected and flagged.

---
 rtl/credit_return_pkg.sv | 18 +
 rtl/wuf_line_ram.sv | 28 ++
 rtl/wide_unpack_fifo.sv | 130 +++++++++++++
 tb/tb_wide_unpack_fifo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/credit_return_pkg.sv
// Shared widths, types and helpers for the credit-return datapath.
package credit_return_pkg;

    localparam int WORD_W         = 16;
    localparam int LINE_W         = 256;
    localparam int WORDS_PER_LINE = 16;
    localparam int SIZE_W         = 4;
    localparam int ENTRY_W        = LINE_W + SIZE_W;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [SIZE_W-1:0] size_t;

    // A size tag of zero encodes a completely full line.
    function automatic logic [4:0] eff_size(input size_t size);
        return (size == '0) ? 5'd16 : {1'b0, size};
    endfunction

endpackage

// File: rtl/wuf_line_ram.sv
// Line storage for wide_unpack_fifo: registered write, asynchronous read so the
// head line is available combinationally for show-ahead output.
module wuf_line_ram
    import credit_return_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem_reg [DEPTH];

    // Storage is deliberately never cleared; the pointers define validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/wide_unpack_fifo.sv
// 256-bit line FIFO that unpacks each line into 16-bit words, lowest first,
// in show-ahead form. Define WUF_LEVEL_EN to add the stored-word level port.
module wide_unpack_fifo
    import credit_return_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic [255:0]      data_i,
    input  logic [3:0]        size_i,
    input  logic              data_we,
    output logic [15:0]       data_o,
    input  logic              data_rd,
    output logic              full,
    output logic              empty,
    output logic              overflow
`ifdef WUF_LEVEL_EN
    ,
    output logic [$clog2(DEPTH*WORDS_PER_LINE):0] level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH*WORDS_PER_LINE) + 1;

    logic [AW:0]          wr_ptr_reg, wr_ptr_next;
    logic [AW:0]          rd_ptr_reg, rd_ptr_next;
    logic [3:0]           word_idx_reg, word_idx_next;
    logic                 overflow_reg, overflow_next;

    logic                 wr_accept;
    logic                 rd_accept;
    logic                 last_word;
    logic [ENTRY_W-1:0]   head_entry;
    line_t                head_line;
    size_t                head_size;
    logic [WORD_W-1:0]    head_words [WORDS_PER_LINE];

    // Flags come only from registered pointers, never from the strobes.
    assign full  = ((wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {AW{1'b0}}});
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    assign wr_accept = data_we && !full;
    assign rd_accept = data_rd && !empty;

    wuf_line_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_line_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr_reg[AW-1:0]),
        .wdata ({size_i, data_i}),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (head_entry)
    );

    assign head_line = head_entry[LINE_W-1:0];
    assign head_size = head_entry[ENTRY_W-1:LINE_W];

    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word_slice
        assign head_words[gi] = head_line[gi*WORD_W +: WORD_W];
    end

    assign data_o    = head_words[word_idx_reg];
    assign last_word = ({1'b0, word_idx_reg} == (eff_size(head_size) - 5'd1));

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        word_idx_next = word_idx_reg;
        overflow_next = overflow_reg;

        if (wr_accept) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        // Uses the pre-read full, so a write racing a last-word pop still drops.
        if (data_we && full) begin
            overflow_next = 1'b1;
        end
        if (rd_accept) begin
            if (last_word) begin
                word_idx_next = '0;
                rd_ptr_next   = rd_ptr_reg + 1'b1;
            end else begin
                word_idx_next = word_idx_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            word_idx_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            word_idx_reg <= word_idx_next;
            overflow_reg <= overflow_next;
        end
    end

    assign overflow = overflow_reg;

`ifdef WUF_LEVEL_EN
    logic [LW-1:0] level_reg, level_next;
    logic [LW-1:0] level_add;
    logic [LW-1:0] level_sub;

    always_comb begin
        level_add  = wr_accept ? LW'(eff_size(size_i)) : '0;
        level_sub  = rd_accept ? LW'(1) : '0;
        level_next = level_reg + level_add - level_sub;
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            level_reg <= '0;
        end else begin
            level_reg <= level_next;
        end
    end

    assign level = level_reg;
`endif

endmodule

// File: tb/tb_wide_unpack_fifo.sv
// Scoreboard bench for wide_unpack_fifo; level checks run when WUF_LEVEL_EN is defined.
module tb_wide_unpack_fifo;

    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         reset_p;
    logic [255:0] data_i;
    logic [3:0]   size_i;
    logic         data_we;
    logic [15:0]  data_o;
    logic         data_rd;
    logic         full;
    logic         empty;
    logic         overflow;
`ifdef WUF_LEVEL_EN
    logic [8:0]   level;
`endif

    wide_unpack_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_p  (reset_p),
        .data_i   (data_i),
        .size_i   (size_i),
        .data_we  (data_we),
        .data_o   (data_o),
        .data_rd  (data_rd),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
`ifdef WUF_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] w;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    int   model_lines = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [255:0] make_line(input logic [15:0] base);
        logic [255:0] l;
        for (int k = 0; k < 16; k++) l[16*k +: 16] = base + 16'(k);
        return l;
    endfunction

    // Drives a write for the coming edge and predicts acceptance from the model.
    task automatic set_write(input logic [15:0] base, input logic [3:0] size);
        int n;
        data_i  = make_line(base);
        size_i  = size;
        data_we = 1'b1;
        n = (size == 4'd0) ? 16 : int'(size);
        if (model_lines < DEPTH) begin
            model_lines++;
            for (int k = 0; k < n; k++) begin
                exp_t e;
                e.w    = base + 16'(k);
                e.last = (k == n - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_p = 1'b1;
        data_we = 1'b0;
        data_rd = 1'b0;
        exp_q.delete();
        model_lines = 0;
        step();
        reset_p = 1'b0;
    endtask

    // Monitor: every accepted pop is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!reset_p && data_rd && !empty) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", data_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pop_word", {16'h0, data_o}, {16'h0, e.w});
                if (e.last) model_lines--;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        data_i = '0; size_i = '0; data_we = 0; data_rd = 0; reset_p = 1;
        step(); step();
        do_reset();
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
`ifdef WUF_LEVEL_EN
        check("reset_level", 32'(level), 32'd0);
`endif

        // Full 16-word line, streamed with data_rd held high.
        set_write(16'hA000, 4'd0);
        check("pre_write_empty", 32'(empty), 32'd1);
        step();
        data_we = 0;
        check("post_write_empty", 32'(empty), 32'd0);
        check("head_word", 32'(data_o), 32'hA000);
        p0 = pops;
        data_rd = 1;
        repeat (16) step();
        data_rd = 0;
        check("line16_pops", 32'(pops - p0), 32'd16);
        check("line16_empty", 32'(empty), 32'd1);

        // Short lines back to back: no bubble across the boundary.
        set_write(16'h0001, 4'd3);
        step();
        set_write(16'h00FF, 4'd1);
        data_rd = 1;
        p0 = pops;
        step();
        data_we = 0;
        repeat (3) step();
        data_rd = 0;
        check("short_pops", 32'(pops - p0), 32'd4);
        check("short_empty", 32'(empty), 32'd1);

        // Fill all entries (pointer wrap), overflow on the 17th, then drain.
        for (int i = 0; i < DEPTH; i++) begin
            set_write(16'h4000 + 16'(i * 16'h0100), 4'd0);
            step();
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_no_overflow", 32'(overflow), 32'd0);
        set_write(16'hEE00, 4'd0);
        step();
        data_we = 0;
        check("overflow_set", 32'(overflow), 32'd1);
        check("overflow_full", 32'(full), 32'd1);
        p0 = pops;
        data_rd = 1;
        repeat (256) step();
        data_rd = 0;
        check("drain_pops", 32'(pops - p0), 32'd256);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_scoreboard", 32'(exp_q.size()), 32'd0);
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Reads while empty are ignored; toggled reads keep word order.
        p0 = pops;
        data_rd = 1;
        repeat (3) step();
        data_rd = 0;
        check("idle_empty", 32'(empty), 32'd1);
        set_write(16'h5500, 4'd4);
        step();
        data_we = 0;
        check("idle_head", 32'(data_o), 32'h5500);
        for (int i = 0; i < 8; i++) begin
            data_rd = (i % 2 == 0);
            step();
        end
        data_rd = 0;
        check("toggle_pops", 32'(pops - p0), 32'd4);
        check("toggle_empty", 32'(empty), 32'd1);

        // Reset part way through a line.
        set_write(16'h7700, 4'd0);
        step();
        data_we = 0;
        data_rd = 1;
        repeat (5) step();
        data_rd = 0;
        check("mid_line_head", 32'(data_o), 32'h7705);
        do_reset();
        check("mid_reset_empty", 32'(empty), 32'd1);
        check("mid_reset_overflow", 32'(overflow), 32'd0);
        check("mid_reset_full", 32'(full), 32'd0);
        set_write(16'h8800, 4'd2);
        step();
        data_we = 0;
        check("restart_head", 32'(data_o), 32'h8800);
        data_rd = 1;
        repeat (2) step();
        data_rd = 0;
        check("restart_empty", 32'(empty), 32'd1);

`ifdef WUF_LEVEL_EN
        set_write(16'h9000, 4'd0);
        step();
        set_write(16'h9100, 4'd5);
        step();
        set_write(16'h9200, 4'd2);
        step();
        data_we = 0;
        check("level_23", 32'(level), 32'd23);
        data_rd = 1;
        repeat (4) step();
        data_rd = 0;
        check("level_19", 32'(level), 32'd19);
        set_write(16'h9300, 4'd1);
        data_rd = 1;
        step();
        data_we = 0;
        data_rd = 0;
        check("level_wr_rd", 32'(level), 32'd19);
        data_rd = 1;
        repeat (19) step();
        data_rd = 0;
        check("level_drained", 32'(level), 32'd0);
        check("level_empty", 32'(empty), 32'd1);
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
